// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for the HI/LO multiply/divide unit
//   op_t    : {is_div, is_unsigned}, matching the decoder's {hi_src==10, unsigned_instr}
//   state_t : IDLE -> RUN -> SIGNFIX -> DONE
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SIGNFIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// rtl/hilo_muldiv_seq_if.sv - pipeline-side interface of the HI/LO multiply/divide unit
//   master (pipeline): drives start, op, op_a, op_b, mthi_we, mtlo_we, wdata, rd_hilo
//   slave  (unit)    : drives hi, lo, busy, stall, done, div_by_zero
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, op_a, op_b, mthi_we, mtlo_we, wdata, rd_hilo,
        input  hi, lo, busy, stall, done, div_by_zero
    );

    modport slave (
        input  start, op, op_a, op_b, mthi_we, mtlo_we, wdata, rd_hilo,
        output hi, lo, busy, stall, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of unsigned shift-add multiply or restoring divide
//   is_div         : 1 = divide step, 0 = multiply step
//   acc_hi, acc_lo : current accumulator (partial product / remainder, multiplier / dividend-quotient)
//   operand        : multiplicand or divisor magnitude
//   nxt_hi, nxt_lo : accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift
        // the whole {carry, hi, lo} right by one.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the remainder and subtract
        // the divisor if it fits; the difference is always < divisor so W bits suffice.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;

        nxt_hi = {sum[WIDTH:1]};
        nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = fits ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], fits};
        end
    end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - sequential MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of hilo_muldiv_seq_if (start/op/operands, MTHI/MTLO, MFHI/MFLO hazard,
//                hi/lo, busy, stall, done, div_by_zero)
module hilo_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int CYCLES = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    hilo_muldiv_seq_if.slave   bus
);
    localparam int             CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, b_mag, hi_q, lo_q;
    logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic               is_div, sign_a, sign_b, dbz;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_in_mag;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (b_mag),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Magnitudes of the incoming operands; unsigned ops pass raw values.
    always_comb begin
        a_neg    = ~bus.op[0] & bus.op_a[WIDTH-1];
        b_neg    = ~bus.op[0] & bus.op_b[WIDTH-1];
        a_mag    = a_neg ? -bus.op_a : bus.op_a;
        b_in_mag = b_neg ? -bus.op_b : bus.op_b;
    end

    // Sign correction applied in SIGNFIX. A zero divisor drives every trial
    // subtract true, leaving quotient all-ones and remainder |op_a|; the
    // remainder then picks up the dividend sign (giving op_a back) while the
    // quotient is left unnegated.
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        fix_hi   = acc_hi;
        fix_lo   = acc_lo;
        if (is_div) begin
            fix_lo = ((sign_a ^ sign_b) && !dbz) ? -acc_lo : acc_lo;
            fix_hi = sign_a ? -acc_hi : acc_hi;
        end else begin
            if (sign_a ^ sign_b) begin
                prod_fix = -{acc_hi, acc_lo};
            end
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nxt = ST_RUN;
            ST_RUN:     if (cnt == LAST) state_nxt = ST_SIGNFIX;
            ST_SIGNFIX: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            b_mag  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // start wins over a same-cycle MTHI/MTLO, which is dropped
                        is_div <= bus.op[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        dbz    <= bus.op[1] && (bus.op_b == '0);
                        b_mag  <= b_in_mag;
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        cnt    <= '0;
                    end else begin
                        if (bus.mthi_we) hi_q <= bus.wdata;
                        if (bus.mtlo_we) lo_q <= bus.wdata;
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                end
                ST_SIGNFIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    // In DONE hi/lo already hold the result, so a pending MFHI/MFLO may
    // proceed; a new start or MT* there is still refused and must be held.
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.div_by_zero = (state == ST_DONE) && dbz;
    assign bus.stall       = (state != ST_IDLE) &&
                             (bus.start || bus.mthi_we || bus.mtlo_we ||
                              (bus.rd_hilo && state != ST_DONE));
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - self-checking bench for hilo_muldiv_seq against an arithmetic reference model
module tb_hilo_muldiv_seq;
    localparam int W   = 32;
    localparam int CYC = W;
    localparam int LAT = CYC + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus ();

    hilo_muldiv_seq #(.WIDTH(W), .CYCLES(CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain wide arithmetic on the architectural meaning of each op.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic edbz);
        logic [63:0] p;
        longint la, lb, q, r;
        edbz = 1'b0;
        if (!op[1]) begin
            if (op[0]) p = {32'b0, a} * {32'b0, b};
            else       p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            ehi = p[63:32];
            elo = p[31:0];
        end else if (b == '0) begin
            ehi = a; elo = '1; edbz = 1'b1;
        end else begin
            if (op[0]) begin la = longint'({32'b0, a}); lb = longint'({32'b0, b}); end
            else       begin la = longint'($signed(a)); lb = longint'($signed(b)); end
            q = la / lb;
            r = la % lb;
            elo = q[31:0];
            ehi = r[31:0];
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb);
        logic [W-1:0] ehi, elo;
        logic edbz;
        int lat;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
        if (disturb) begin bus.mthi_we = 1'b1; bus.wdata = ~m_hi; end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi_we = 1'b0;
        for (int n = 1; n <= LAT + 6; n++) begin
            @(negedge clk);
            if (n == 1 || n == CYC + 1) begin
                check("hold_hi", bus.hi, m_hi);
                check("hold_lo", bus.lo, m_lo);
            end
            if (disturb && n == 3) begin
                bus.mtlo_we = 1'b1; bus.wdata = ~m_lo; #1;
                check("stall_mt_busy", bus.stall, 1'b1);
            end
            if (disturb && n == 4) bus.mtlo_we = 1'b0;
            if (bus.done) begin lat = n; break; end
        end
        model(op, a, b, ehi, elo, edbz);
        check("latency", lat, LAT);
        check("hi", bus.hi, ehi);
        check("lo", bus.lo, elo);
        check("div_by_zero", bus.div_by_zero, edbz);
        m_hi = ehi; m_lo = elo;
        @(negedge clk);
        check("done_pulse", bus.done, 1'b0);
    endtask

    task automatic stall_test();
        logic [W-1:0] ehi, elo;
        logic edbz;
        int dones;
        dones = 0;
        @(negedge clk);
        bus.rd_hilo = 1'b1; bus.start = 1'b1; bus.op = 2'b00;
        bus.op_a = 32'd1000; bus.op_b = 32'hFFFF_FFF6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n <= 33)    check("stall_busy", bus.stall, 1'b1);
            if (n == LAT)   check("stall_done", bus.stall, 1'b0);
            if (bus.done) dones++;
            if (n == 5) begin bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd9; end
            if (n == 6) bus.start = 1'b0;
        end
        bus.rd_hilo = 1'b0;
        model(2'b00, 32'd1000, 32'hFFFF_FFF6, ehi, elo, edbz);
        check("single_done", dones, 1);
        check("stall_hi", bus.hi, ehi);
        check("stall_lo", bus.lo, elo);
        m_hi = ehi; m_lo = elo;
    endtask

    task automatic reset_test();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("rst_no_done", dones, 0);
        bus.mthi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.mthi_we = 1'b0; bus.rd_hilo = 1'b1; #1;
        check("mfhi_stall", bus.stall, 1'b0);
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_lo", bus.lo, 0);
        bus.rd_hilo = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0;
        bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wdata = '0; bus.rd_hilo = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_stall", bus.stall, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_dbz", bus.div_by_zero, 1'b0);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        rst_n = 1'b1;

        // MTHI/MTLO in IDLE
        bus.mthi_we = 1'b1; bus.mtlo_we = 1'b1; bus.wdata = 32'hA5A5_0001;
        @(negedge clk);
        bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
        check("mt_hi", bus.hi, 32'hA5A5_0001);
        check("mt_lo", bus.lo, 32'hA5A5_0001);
        m_hi = 32'hA5A5_0001; m_lo = 32'hA5A5_0001;

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b11, 32'd5, 32'd0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 1'b1);
        stall_test();

        for (int i = 0; i < 30; i++) begin
            ra = pick();
            rb = ($urandom_range(0, 5) == 0) ? '0 : pick();
            do_op(2'($urandom_range(0, 3)), ra, rb, (i % 7) == 3);
        end

        reset_test();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
